// File: rtl/mhp_frame_rx.sv
// MHP link receive parser: pops one frame from the eth RX FIFO and decodes
// dst/src/size/{dir,type}/payload, flagging short, long, oversize or filtered frames.
module mhp_frame_rx #(
    parameter int unsigned MAX_PAYLOAD = 42,
    parameter logic [15:0] BCAST_ADDR  = 16'hFFFF
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [7:0]               i_rdata,
    input  logic                     i_rready,
    output logic                     o_rreq,
    input  logic [15:0]              i_my_addr,
    input  logic                     i_filter_en,
    output logic [15:0]              o_dst,
    output logic [15:0]              o_src,
    output logic [15:0]              o_size,
    output logic                     o_dir,
    output logic [6:0]               o_type,
    output logic [8*MAX_PAYLOAD-1:0] o_payload,
    output logic                     o_valid,
    output logic                     o_err,
    output logic [1:0]               o_err_code,
    output logic                     o_busy
);
    localparam int unsigned PW    = 8 * MAX_PAYLOAD;
    localparam logic [15:0] MAX16 = 16'(MAX_PAYLOAD);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAY, S_DRAIN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic            rreq_q, rreq_d;
    logic            rd_pend_q, rd_pend_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [15:0]     sh_dst_q, sh_dst_d, sh_src_q, sh_src_d, sh_size_q, sh_size_d;
    logic [7:0]      sh_dt_q, sh_dt_d;
    logic [PW-1:0]   sh_pay_q, sh_pay_d;
    logic            os_q, os_d, short_q, short_d, long_q, long_d;
    logic [15:0]     dst_q, dst_d, src_q, src_d, size_q, size_d;
    logic [7:0]      dt_q, dt_d;
    logic [PW-1:0]   pay_q, pay_d;
    logic [1:0]      code_q, code_d;
    logic            end_c, ok_c, err_c, filt_c;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_dst_d  = sh_dst_q;
        sh_src_d  = sh_src_q;
        sh_size_d = sh_size_q;
        sh_dt_d   = sh_dt_q;
        sh_pay_d  = sh_pay_q;
        os_d      = os_q;
        short_d   = short_q;
        long_d    = long_q;
        dst_d     = dst_q;
        src_d     = src_q;
        size_d    = size_q;
        dt_d      = dt_q;
        pay_d     = pay_q;
        code_d    = code_q;
        ok_c      = 1'b0;
        err_c     = 1'b0;
        end_c     = !i_rready && !rd_pend_q;
        filt_c    = i_filter_en && (sh_dst_q != i_my_addr) && (sh_dst_q != BCAST_ADDR);
        rd_pend_d = rreq_q && i_rready;

        if (rd_pend_q && cnt_q != 6'd63) cnt_d = cnt_q + 6'd1;

        case (state_q)
            S_IDLE: begin
                if (i_rready) begin
                    state_d  = S_HDR;
                    cnt_d    = '0;
                    sh_pay_d = '0;
                    os_d     = 1'b0;
                    short_d  = 1'b0;
                    long_d   = 1'b0;
                end
            end
            S_HDR: begin
                if (rd_pend_q) begin
                    case (cnt_q)
                        6'd0: sh_dst_d[15:8]  = i_rdata;
                        6'd1: sh_dst_d[7:0]   = i_rdata;
                        6'd2: sh_src_d[15:8]  = i_rdata;
                        6'd3: sh_src_d[7:0]   = i_rdata;
                        6'd4: sh_size_d[15:8] = i_rdata;
                        6'd5: sh_size_d[7:0]  = i_rdata;
                        6'd6: sh_dt_d         = i_rdata;
                        default: ;
                    endcase
                    // size is complete once byte 5 is in, so the branch can use the shadow
                    if (cnt_q == 6'd6) begin
                        if (sh_size_q > MAX16) begin
                            os_d    = 1'b1;
                            state_d = S_DRAIN;
                        end else if (sh_size_q == 16'd0) begin
                            state_d = S_DRAIN;
                        end else begin
                            state_d = S_PAY;
                        end
                    end
                end else if (end_c) begin
                    short_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_PAY: begin
                if (rd_pend_q) begin
                    for (int unsigned i = 0; i < MAX_PAYLOAD; i++) begin
                        if ({26'd0, cnt_q} == i + 32'd7) sh_pay_d[8*i +: 8] = i_rdata;
                    end
                    if ({10'd0, cnt_q} == sh_size_q + 16'd6) state_d = S_DRAIN;
                end else if (end_c) begin
                    short_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DRAIN: begin
                if (rd_pend_q) begin
                    if (!os_q) long_d = 1'b1;
                end else if (end_c) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!i_rst) begin
                    if (os_q || short_q || long_q || filt_c) begin
                        err_c  = 1'b1;
                        code_d = os_q ? 2'd2 : short_q ? 2'd0 : long_q ? 2'd1 : 2'd3;
                    end else begin
                        ok_c   = 1'b1;
                        dst_d  = sh_dst_q;
                        src_d  = sh_src_q;
                        size_d = sh_size_q;
                        dt_d   = sh_dt_q;
                        pay_d  = sh_pay_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        rreq_d = (state_d == S_HDR) || (state_d == S_PAY) || (state_d == S_DRAIN);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            rreq_q    <= 1'b0;
            rd_pend_q <= 1'b0;
            cnt_q     <= '0;
            sh_dst_q  <= '0;
            sh_src_q  <= '0;
            sh_size_q <= '0;
            sh_dt_q   <= '0;
            sh_pay_q  <= '0;
            os_q      <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            dst_q     <= '0;
            src_q     <= '0;
            size_q    <= '0;
            dt_q      <= '0;
            pay_q     <= '0;
            code_q    <= '0;
        end else begin
            state_q   <= state_d;
            rreq_q    <= rreq_d;
            rd_pend_q <= rd_pend_d;
            cnt_q     <= cnt_d;
            sh_dst_q  <= sh_dst_d;
            sh_src_q  <= sh_src_d;
            sh_size_q <= sh_size_d;
            sh_dt_q   <= sh_dt_d;
            sh_pay_q  <= sh_pay_d;
            os_q      <= os_d;
            short_q   <= short_d;
            long_q    <= long_d;
            dst_q     <= dst_d;
            src_q     <= src_d;
            size_q    <= size_d;
            dt_q      <= dt_d;
            pay_q     <= pay_d;
            code_q    <= code_d;
        end
    end

    // Fields present the new frame during the o_valid cycle itself, then stay registered
    assign o_rreq     = rreq_q;
    assign o_dst      = dst_d;
    assign o_src      = src_d;
    assign o_size     = size_d;
    assign o_dir      = dt_d[7];
    assign o_type     = dt_d[6:0];
    assign o_payload  = pay_d;
    assign o_valid    = ok_c;
    assign o_err      = err_c;
    assign o_err_code = code_d;
    assign o_busy     = (state_q != S_IDLE);
endmodule

// File: tb/tb_mhp_frame_rx.sv
// Scoreboard bench for mhp_frame_rx: a FIFO model feeds directed frames, a monitor
// pops expected pulses and compares decoded fields, error codes and pulse latency.
module tb_mhp_frame_rx;
    logic         clk = 1'b0;
    logic         i_rst;
    logic [7:0]   i_rdata;
    logic         i_rready;
    logic         o_rreq;
    logic [15:0]  i_my_addr;
    logic         i_filter_en;
    logic [15:0]  o_dst, o_src, o_size;
    logic         o_dir;
    logic [6:0]   o_type;
    logic [335:0] o_payload;
    logic         o_valid, o_err;
    logic [1:0]   o_err_code;
    logic         o_busy;

    mhp_frame_rx #(.MAX_PAYLOAD(42), .BCAST_ADDR(16'hFFFF)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_rdata(i_rdata), .i_rready(i_rready),
        .o_rreq(o_rreq), .i_my_addr(i_my_addr), .i_filter_en(i_filter_en),
        .o_dst(o_dst), .o_src(o_src), .o_size(o_size), .o_dir(o_dir),
        .o_type(o_type), .o_payload(o_payload), .o_valid(o_valid), .o_err(o_err),
        .o_err_code(o_err_code), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           is_err;
        logic [1:0]   code;
        logic [15:0]  dst, src, size;
        logic         dir;
        logic [6:0]   typ;
        logic [335:0] pay;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    logic [7:0]  fq[$];
    logic [7:0]  fb[$];
    int unsigned cyc = 0;
    int unsigned last_pop = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [335:0] act, input logic [335:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // FIFO model: a pop in cycle t presents its byte on i_rdata from just after the edge
    initial begin
        bit p;
        i_rready = 1'b0;
        i_rdata  = '0;
        forever begin
            @(negedge clk);
            p = o_rreq && i_rready && (fq.size() != 0);
            if (p) last_pop = cyc;
            @(posedge clk);
            #1;
            if (p && fq.size() != 0) i_rdata = fq.pop_front();
            i_rready = (fq.size() != 0);
        end
    end

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_valid || o_err) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_pulse: got valid=%0b err=%0b expected none (cycle %0d)",
                             o_valid, o_err, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_kind_err", {335'd0, o_err}, {335'd0, e.is_err});
                    chk("pulse_kind_valid", {335'd0, o_valid}, {335'd0, !e.is_err});
                    chk("pulse_latency", 336'(cyc), 336'(last_pop + 3));
                    if (e.is_err) chk("err_code", {334'd0, o_err_code}, {334'd0, e.code});
                    chk("dst", {320'd0, o_dst}, {320'd0, e.dst});
                    chk("src", {320'd0, o_src}, {320'd0, e.src});
                    chk("size", {320'd0, o_size}, {320'd0, e.size});
                    chk("dir_type", {328'd0, o_dir, o_type}, {328'd0, e.dir, e.typ});
                    chk("payload", o_payload, e.pay);
                end
            end
        end
    end

    task automatic exp_ok(input logic [15:0] d, input logic [15:0] s, input logic [15:0] sz,
                          input logic dr, input logic [6:0] t, input logic [335:0] pl);
        exp_t e;
        e.is_err = 1'b0; e.code = 2'd0;
        e.dst = d; e.src = s; e.size = sz; e.dir = dr; e.typ = t; e.pay = pl;
        cur = e;
        sb.push_back(e);
    endtask

    task automatic exp_err(input logic [1:0] c);
        exp_t e;
        e = cur;
        e.is_err = 1'b1;
        e.code = c;
        sb.push_back(e);
    endtask

    task automatic send_and_wait(input string name);
        foreach (fb[i]) fq.push_back(fb[i]);
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL timeout_%s: got %0d pending pulses expected 0", name, sb.size());
            sb.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [335:0] pl;
        cur = '{is_err: 1'b0, code: 2'd0, dst: 16'd0, src: 16'd0, size: 16'd0,
                dir: 1'b0, typ: 7'd0, pay: 336'd0};
        i_rst = 1'b1;
        i_my_addr = 16'h0005;
        i_filter_en = 1'b1;
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
        chk("rst_rreq", {335'd0, o_rreq}, 336'd0);
        chk("rst_busy", {335'd0, o_busy}, 336'd0);
        chk("rst_pulses", {334'd0, o_valid, o_err}, 336'd0);
        chk("rst_fields", {o_payload[255:0], o_dst, o_src, o_size, o_dir, o_type, 6'd0, o_err_code}, 336'd0);

        // broadcast dst passes the filter
        fb = {8'hFF, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h02, 8'h92, 8'h01, 8'h10};
        exp_ok(16'hFFFF, 16'h0001, 16'd2, 1'b1, 7'h12, 336'h1001);
        send_and_wait("bcast");

        fb = {8'h00, 8'h07, 8'h00, 8'h03, 8'h00, 8'h00, 8'h45};
        exp_err(2'd3);
        send_and_wait("filtered");

        fb = {8'h00, 8'h05, 8'h00, 8'h09, 8'h00, 8'h05, 8'h01, 8'hAA, 8'hBB, 8'hCC};
        exp_err(2'd0);
        send_and_wait("short");

        fb = {8'h00, 8'h05, 8'h00, 8'h09, 8'h00, 8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44};
        exp_err(2'd1);
        send_and_wait("long");
        chk("long_fifo_empty", 336'(fq.size()), 336'd0);

        fb = {8'h00, 8'h05, 8'h00, 8'h09, 8'h00, 8'h2B, 8'h04};
        for (int i = 0; i < 43; i++) fb.push_back(8'(i + 1));
        exp_err(2'd2);
        send_and_wait("oversize");
        chk("oversize_fifo_empty", 336'(fq.size()), 336'd0);

        fb = {8'h00, 8'h05, 8'h00, 8'h0A, 8'h00, 8'h2A, 8'h85};
        pl = '0;
        for (int i = 0; i < 42; i++) begin
            fb.push_back(8'(i + 1));
            pl[8*i +: 8] = 8'(i + 1);
        end
        exp_ok(16'h0005, 16'h000A, 16'd42, 1'b1, 7'h05, pl);
        send_and_wait("max_size");
        chk("max_last_byte", {328'd0, o_payload[335:328]}, 336'h2A);

        // abandon a frame mid-payload with reset
        i_filter_en = 1'b0;
        fb = {8'h00, 8'h05, 8'h00, 8'h09, 8'h00, 8'h05, 8'h01, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        foreach (fb[i]) fq.push_back(fb[i]);
        repeat (11) @(negedge clk);
        i_rst = 1'b1;
        fq.delete();
        @(negedge clk);
        i_rst = 1'b0;
        chk("abort_rreq_low", {335'd0, o_rreq}, 336'd0);
        chk("abort_busy_low", {335'd0, o_busy}, 336'd0);
        repeat (4) @(negedge clk);
        fb = {8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h02, 8'h7F, 8'hAB, 8'hCD};
        exp_ok(16'h1234, 16'h5678, 16'd2, 1'b0, 7'h7F, 336'hCDAB);
        send_and_wait("after_reset");

        // matching dst with filter on; stale payload bytes from the 42-byte frame must be gone
        i_filter_en = 1'b1;
        fb = {8'h00, 8'h05, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h5A};
        exp_ok(16'h0005, 16'h0001, 16'd1, 1'b0, 7'h00, 336'h5A);
        send_and_wait("match");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
